sram_port_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between the core's instruction and data request channels, replacing the split inst/data SRAM wiring when the SoC provides a unified memory. Each requester uses a request/addr_ok/data_ok handshake. Kseg0/kseg1 virtual addresses are translated to physical addresses. Arbitration gives data priority, with a bounded-starvation guarantee for instruction fetch.

---
 rtl/sram_port_arbiter_if.sv | 52 +++++
 rtl/sram_port_arbiter.sv | 96 +++++++++
 tb/tb_sram_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// ============================================================================
//  Module      : sram_port_arbiter_if
//  Description : Bundles the instruction and data request channels and the
//                single-port SRAM bus of sram_port_arbiter.
//                master : arbiter side (drives addr_ok/data_ok/rdata, sram_*)
//                slave  : requester/SRAM side (drives req/addr/wdata, rdata)
//  Ports       : inst channel  i_req, i_addr, i_addr_ok, i_data_ok, i_rdata
//                data channel  d_req, d_wen, d_addr, d_wdata, d_addr_ok,
//                              d_data_ok, d_rdata
//                sram bus      sram_en, sram_wen, sram_addr, sram_wdata,
//                              sram_rdata
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, sram_rdata,
        output i_addr_ok, i_data_ok, i_rdata,
               d_addr_ok, d_data_ok, d_rdata,
               sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, sram_rdata,
        input  i_addr_ok, i_data_ok, i_rdata,
               d_addr_ok, d_data_ok, d_rdata,
               sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares one single-port synchronous SRAM between the
//                instruction and data request channels. Data has priority;
//                an instruction request waits at most STARVE_LIMIT data
//                grants. kseg0/kseg1 addresses are mapped to physical.
//                Accept in cycle N (addr_ok), response in cycle N+1 (data_ok).
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous active-high reset
//                bus    - request channels and SRAM bus (master modport)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    sram_port_arbiter_if.master    bus
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    // kseg0 (100) and kseg1 (101) both drop the top three bits.
    function automatic logic [31:0] f_translate(input logic [31:0] vaddr);
        if (vaddr[31:30] == 2'b10) begin
            return {3'b000, vaddr[28:0]};
        end
        return vaddr;
    endfunction

    logic [3:0] r_streak;
    logic [1:0] r_owner;        // {inst, data}, one-hot or zero

    logic       w_grant_i;
    logic       w_grant_d;
    logic [3:0] w_streak_nxt;

    // Grants are masked while reset is high so nothing is issued to the SRAM.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!reset) begin
            w_grant_i = bus.i_req && (!bus.d_req || (r_streak == c_starve_limit));
            w_grant_d = bus.d_req && !w_grant_i;
        end
    end

    // The streak only counts data grants that made an instruction wait.
    always_comb begin
        w_streak_nxt = 4'd0;
        if (w_grant_d && bus.i_req) begin
            w_streak_nxt = (r_streak == c_starve_limit) ? c_starve_limit
                                                        : r_streak + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= 4'd0;
            r_owner  <= 2'b00;
        end else begin
            r_streak <= w_streak_nxt;
            r_owner  <= {w_grant_i, w_grant_d};
        end
    end

    always_comb begin
        bus.i_addr_ok  = w_grant_i;
        bus.d_addr_ok  = w_grant_d;
        bus.sram_en    = w_grant_i || w_grant_d;
        bus.sram_wen   = 4'd0;
        bus.sram_wdata = 32'd0;
        bus.sram_addr  = 32'd0;
        if (w_grant_i) begin
            bus.sram_addr = f_translate(bus.i_addr);
        end else if (w_grant_d) begin
            bus.sram_addr  = f_translate(bus.d_addr);
            bus.sram_wen   = bus.d_wen;
            bus.sram_wdata = bus.d_wdata;
        end
    end

    // Response side: SRAM read data is steered to whichever channel was
    // granted last cycle; the other channel sees zero.
    always_comb begin
        bus.i_data_ok = r_owner[1];
        bus.d_data_ok = r_owner[0];
        bus.i_rdata   = r_owner[1] ? bus.sram_rdata : 32'd0;
        bus.d_rdata   = r_owner[0] ? bus.sram_rdata : 32'd0;
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Scoreboard bench for sram_port_arbiter with a behavioural
//                synchronous SRAM and a reference memory image.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sram_port_arbiter_if dif ();

    sram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural SRAM ----------------
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (dif.sram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dif.sram_wen[b]) mem[dif.sram_addr[9:2]][8*b +: 8] <= dif.sram_wdata[8*b +: 8];
            end
            dif.sram_rdata <= mem[dif.sram_addr[9:2]];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  ch;     // 0 none, 1 inst, 2 data
        logic        wr;
        logic [31:0] data;
    } exp_t;

    exp_t      q[$];
    logic [3:0] m_streak = 4'd0;

    function automatic logic [31:0] m_translate(input logic [31:0] v);
        logic [2:0] top;
        top = v[31:29];
        if (top == 3'b100 || top == 3'b101) return {3'b000, v[28:0]};
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        exp_t        n;
        logic        gi, gd;
        logic [31:0] pa;
        logic [7:0]  idx;

        e = '{ch: 2'd0, wr: 1'b0, data: 32'd0};
        if (q.size() > 0) e = q.pop_front();
        if (reset) e = '{ch: 2'd0, wr: 1'b0, data: 32'd0};

        check("i_data_ok", {31'd0, dif.i_data_ok}, {31'd0, e.ch == 2'd1});
        check("d_data_ok", {31'd0, dif.d_data_ok}, {31'd0, e.ch == 2'd2});
        check("i_rdata", dif.i_rdata, (e.ch == 2'd1) ? e.data : 32'd0);
        if (!(e.ch == 2'd2 && e.wr)) begin
            check("d_rdata", dif.d_rdata, (e.ch == 2'd2) ? e.data : 32'd0);
        end
        check("addr_ok_excl", {31'd0, dif.i_addr_ok & dif.d_addr_ok}, 32'd0);

        n = '{ch: 2'd0, wr: 1'b0, data: 32'd0};
        if (reset) begin
            check("rst_sram_en", {31'd0, dif.sram_en}, 32'd0);
            check("rst_addr_ok", {30'd0, dif.i_addr_ok, dif.d_addr_ok}, 32'd0);
            m_streak = 4'd0;
            q.delete();
        end else begin
            gi = dif.i_req && (!dif.d_req || m_streak == 4'(STARVE_LIMIT));
            gd = dif.d_req && !gi;
            check("i_addr_ok", {31'd0, dif.i_addr_ok}, {31'd0, gi});
            check("d_addr_ok", {31'd0, dif.d_addr_ok}, {31'd0, gd});
            check("sram_en", {31'd0, dif.sram_en}, {31'd0, gi | gd});
            if (gi) begin
                pa = m_translate(dif.i_addr);
                idx = pa[9:2];
                check("sram_addr_i", dif.sram_addr, pa);
                check("sram_wen_i", {28'd0, dif.sram_wen}, 32'd0);
                check("sram_wdata_i", dif.sram_wdata, 32'd0);
                n = '{ch: 2'd1, wr: 1'b0, data: ref_mem[idx]};
            end else if (gd) begin
                pa = m_translate(dif.d_addr);
                idx = pa[9:2];
                check("sram_addr_d", dif.sram_addr, pa);
                check("sram_wen_d", {28'd0, dif.sram_wen}, {28'd0, dif.d_wen});
                check("sram_wdata_d", dif.sram_wdata, dif.d_wdata);
                n = '{ch: 2'd2, wr: (dif.d_wen != 4'd0), data: ref_mem[idx]};
                for (int b = 0; b < 4; b++) begin
                    if (dif.d_wen[b]) ref_mem[idx][8*b +: 8] = dif.d_wdata[8*b +: 8];
                end
            end
            if (gd && dif.i_req) m_streak = (m_streak == 4'(STARVE_LIMIT)) ? m_streak : m_streak + 4'd1;
            else                 m_streak = 4'd0;
        end
        q.push_back(n);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] seq;

    initial begin
        dif.i_req = 1'b0; dif.i_addr = 32'd0;
        dif.d_req = 1'b0; dif.d_wen = 4'd0; dif.d_addr = 32'd0; dif.d_wdata = 32'd0;
        dif.sram_rdata = 32'd0;
        for (int k = 0; k < 256; k++) begin
            mem[k]     = 32'hA500_0000 + 32'(k);
            ref_mem[k] = 32'hA500_0000 + 32'(k);
        end
        mem[0]     = 32'h2408_0001;
        ref_mem[0] = 32'h2408_0001;

        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // inst-only read through kseg1
        dif.i_req = 1'b1; dif.i_addr = 32'hBFC0_0000;
        @(negedge clk);
        check("inst_paddr", dif.sram_addr, 32'h1FC0_0000);
        cyc();
        dif.i_req = 1'b0;
        @(negedge clk);
        check("inst_rdata", dif.i_rdata, 32'h2408_0001);
        cyc();

        // data write then read, same address
        dif.d_req = 1'b1; dif.d_addr = 32'h8000_0010; dif.d_wen = 4'hF; dif.d_wdata = 32'hDEAD_BEEF;
        cyc();
        dif.d_wen = 4'h0; dif.d_wdata = 32'd0;
        cyc();
        dif.d_req = 1'b0;
        @(negedge clk);
        check("wr_rd_data", dif.d_rdata, 32'hDEAD_BEEF);
        cyc();

        // partial-byte write
        dif.d_req = 1'b1; dif.d_addr = 32'h8000_0010; dif.d_wen = 4'b0101; dif.d_wdata = 32'h1122_3344;
        cyc();
        dif.d_wen = 4'h0;
        cyc();
        dif.d_req = 1'b0;
        @(negedge clk);
        check("byte_wr_data", dif.d_rdata, 32'hDE22_BE44);
        cyc();

        // contention: expect D,D,D,D,I,D,D,D,D,I
        dif.i_req = 1'b1; dif.i_addr = 32'hBFC0_0000;
        dif.d_req = 1'b1; dif.d_addr = 32'h8000_0010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seq[k] = dif.i_addr_ok;
            cyc();
        end
        dif.i_req = 1'b0; dif.d_req = 1'b0;
        check("contention_seq", {22'd0, seq}, 32'h0000_0210);
        cyc();

        // useg passthrough, back-to-back reads
        dif.d_req = 1'b1; dif.d_addr = 32'h0040_0000;
        cyc();
        dif.d_addr = 32'h0040_0004;
        @(negedge clk);
        check("useg_rd0", dif.d_rdata, 32'h2408_0001);
        check("useg_addr1", dif.sram_addr, 32'h0040_0004);
        cyc();
        dif.d_req = 1'b0;
        @(negedge clk);
        check("useg_rd1", dif.d_rdata, 32'hA500_0001);
        cyc();

        // reset in the cycle after an accept, request held during reset
        dif.d_req = 1'b1; dif.d_addr = 32'h8000_0010;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        check("rst_no_data_ok", {31'd0, dif.d_data_ok}, 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", {31'd0, dif.d_addr_ok}, 32'd1);
        cyc();
        dif.d_req = 1'b0;
        cyc();

        // idle
        repeat (4) cyc();
        @(negedge clk);
        check("idle_en", {31'd0, dif.sram_en}, 32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
